// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension funct3 encodings, mul/div FSM states and
// sign helpers used by the iterative multiply/divide unit.
package riscv_pkg;

   localparam int RV_XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   // Magnitude of x when it is to be read as signed; raw value otherwise.
   function automatic logic [RV_XLEN-1:0] abs_val(input logic [RV_XLEN-1:0] x,
                                                  input logic is_signed);
      return (is_signed && x[RV_XLEN-1]) ? -x : x;
   endfunction

   function automatic logic [2*RV_XLEN-1:0] negate(input logic [2*RV_XLEN-1:0] x,
                                                   input logic en);
      return en ? -x : x;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared 2*XLEN shift register runs
// XLEN shift-add (multiply) or restoring-subtract (divide) steps per operation.
module muldiv_unit
   import riscv_pkg::*;
#(
   parameter int XLEN = RV_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output muldiv_state_t   state_dbg
);

   // Handshake: start is taken only while busy=0; busy stays high from the cycle
   // after accept through the done cycle; done is a one-cycle pulse qualifying
   // result/rd_out. A start seen while busy=1 is dropped, never queued.

   localparam int CW = $clog2(XLEN) + 1;
   localparam int AW = 2 * XLEN;

   muldiv_state_t   state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [XLEN-1:0] opb_q, opb_d;
   logic [2:0]      f3_q, f3_d;
   logic            neg_q, neg_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            a_signed, b_signed, a_neg, b_neg, fast, last_iter;
   logic [XLEN-1:0] mag_a, mag_b, fast_res, div_sel, result_fin;
   logic [XLEN:0]   mul_sum, div_trial;
   logic [AW-1:0]   mul_step, div_step, acc_step, fin_full;

   always_comb begin
      a_signed = (funct3 != F3_MULHU) && !(funct3[2] && funct3[0]);
      b_signed = a_signed && (funct3 != F3_MULHSU);
      a_neg    = a_signed && op_a[XLEN-1];
      b_neg    = b_signed && op_b[XLEN-1];
      mag_a    = abs_val(op_a, a_signed);
      mag_b    = abs_val(op_b, b_signed);
      fast     = 1'b0;
      fast_res = '0;
      if (funct3[2]) begin
         if (op_b == '0) begin
            fast     = 1'b1;
            fast_res = funct3[1] ? op_a : '1;
         end else if (b_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1)) begin
            fast     = 1'b1;
            fast_res = funct3[1] ? '0 : op_a;
         end
      end
   end

   // Multiply: low half holds the shrinking multiplier, high half accumulates.
   // Divide: high half is the partial remainder, low half dividend/quotient.
   always_comb begin
      mul_sum   = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_step  = {mul_sum, acc_q[XLEN-1:1]};
      div_trial = acc_q[AW-2:XLEN-1] - {1'b0, opb_q};
      div_step  = div_trial[XLEN] ? {acc_q[AW-2:0], 1'b0}
                                  : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      acc_step  = f3_q[2] ? div_step : mul_step;
      div_sel   = f3_q[1] ? acc_step[AW-1:XLEN] : acc_step[XLEN-1:0];
      fin_full  = negate(f3_q[2] ? {{XLEN{1'b0}}, div_sel} : acc_step, neg_q);
      result_fin = (f3_q[2] || (f3_q[1:0] == 2'b00)) ? fin_full[XLEN-1:0]
                                                     : fin_full[AW-1:XLEN];
      last_iter = (cnt_q == CW'(XLEN - 1));
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      rd_d     = rd_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               f3_d  = funct3;
               rd_d  = rd_in;
               neg_d = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
               cnt_d = '0;
               opb_d = mag_b;
               acc_d = {{XLEN{1'b0}}, mag_a};
               if (fast) begin
                  result_d = fast_res;
                  state_d  = DONE;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
               result_d = result_fin;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         rd_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         rd_q     <= rd_d;
         result_q <= result_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign result    = result_q;
   assign rd_out    = rd_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued ops push expected result/rd/latency,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
   import riscv_pkg::*;

   localparam int W = 77;  // {issue_cyc[31:0], latency[7:0], rd[4:0], result[31:0]}

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [2:0]    funct3;
   logic [31:0]   op_a, op_b;
   logic [4:0]    rd_in;
   logic          busy, done;
   logic [31:0]   result;
   logic [4:0]    rd_out;
   muldiv_state_t state_dbg;

   int            cyc = 0;
   int            n_checks = 0;
   int            n_fail = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  mon_e;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
      .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, pending=%0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      logic [63:0] ea, eb;
      logic [31:0] r;
      logic        ovf;
      sa  = longint'(signed'(a));
      sb  = longint'(signed'(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      ea  = {32'd0, a};
      eb  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r   = '0;
      case (f)
         F3_MUL:    begin p = sa * sb; r = p[31:0];  end
         F3_MULH:   begin p = sa * sb; r = p[63:32]; end
         F3_MULHSU: begin p = sa * ub; r = p[63:32]; end
         F3_MULHU:  begin p = ea * eb; r = p[63:32]; end
         F3_DIV: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (ovf) r = 32'h8000_0000;
            else begin p = sa / sb; r = p[31:0]; end
         end
         F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         F3_REM: begin
            if (b == 0) r = a;
            else if (ovf) r = 32'd0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default:   r = (b == 0) ? a : 32'(ua % ub);
      endcase
      return r;
   endfunction

   function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f[2] && (b == 0)) return 1;
      if ((f == F3_DIV || f == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         check("done_has_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("result", result, mon_e[31:0]);
            check("rd_out", 32'(rd_out), 32'(mon_e[36:32]));
            check("latency", 32'(cyc - int'(mon_e[76:45])), 32'(mon_e[44:37]));
            check("busy_with_done", 32'(busy), 32'd1);
         end
      end
   end

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      int waited = 0;
      @(negedge clk);
      while (busy && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("issue_idle", 32'(busy), 32'd0);
      funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
      exp_q.push_back({32'(cyc), 8'(exp_latency(f, a, b)), rd, ref_model(f, a, b)});
      @(negedge clk);
      start  = 1'b0;
      funct3 = 3'($urandom_range(0, 7));
      op_a   = $urandom();
      op_b   = $urandom();
      rd_in  = 5'($urandom_range(0, 31));
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_rd_out", 32'(rd_out), 32'd0);
      rst = 1'b0;

      issue(F3_MUL, 32'd7, -32'd3, 5'd5);
      drain();
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'd0);

      issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
      issue(F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd2);
      issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      issue(F3_DIV, -32'd20, 32'd3, 5'd4);
      issue(F3_REM, -32'd20, 32'd3, 5'd6);
      issue(F3_DIVU, 32'd20, 32'd3, 5'd7);
      issue(F3_REMU, 32'd20, 32'd3, 5'd8);
      issue(F3_DIV, 32'd5, 32'd0, 5'd9);
      issue(F3_REMU, 32'd5, 32'd0, 5'd10);
      issue(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
      issue(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
      drain();

      // Abort mid-operation: outputs clear at once and the pending op never completes.
      issue(F3_DIVU, 32'd1000, 32'd7, 5'd13);
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_rd_out", 32'(rd_out), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      issue(F3_MUL, 32'd123, 32'd456, 5'd14);
      drain();

      // A second start during BUSY is dropped; a start right after done is taken.
      issue(F3_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15);
      repeat (4) @(negedge clk);
      funct3 = F3_DIVU; op_a = 32'd99; op_b = 32'd9; rd_in = 5'd30; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      issue(F3_REM, 32'd17, -32'd5, 5'd16);
      drain();

      for (int i = 0; i < 40; i++) begin
         issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)));
      end
      drain();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
